if_id_skid: RTL

//  Parametrised IF/ID pipeline stage with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/if_id_skid_pkg.sv | 12 +
 rtl/if_id_skid_pipe_slot.sv | 34 +++
 rtl/if_id_skid.sv | 109 ++++++++++
 3 files changed

// File: rtl/if_id_skid_pkg.sv
// Shared constants for the IF/ID skid stage: bubble encodings and fetch exception codes.
package if_id_skid_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [3:0] EXC_NONE       = 4'h0;
    localparam logic [3:0] EXC_IF_MISALGN = 4'h1;
    localparam logic [3:0] EXC_IF_FAULT   = 4'h2;
    localparam logic [3:0] EXC_IF_PAGE    = 4'h3;

endpackage

// File: rtl/if_id_skid_pipe_slot.sv
// One pipeline holding slot: a valid bit plus W-bit payload with load/clear controls.
module pipe_slot
    import if_id_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID stage with valid/ready handshake, optional 2-entry skid buffer and flush.
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              EXC_W    = 4,
    parameter bit              SKID_EN  = 1'b1,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(INST_NOP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [ILEN-1:0]  inst_i,
    input  logic [XLEN-1:0]  inst_addr_i,
    input  logic             pred_taken_i,
    input  logic [EXC_W-1:0] exc_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ILEN-1:0]  inst_o,
    output logic [XLEN-1:0]  inst_addr_o,
    output logic             pred_taken_o,
    output logic [EXC_W-1:0] exc_o
);

    localparam int PW = EXC_W + 1 + XLEN + ILEN;

    logic          w_main_v;
    logic          w_skid_v;
    logic [PW-1:0] w_main_pl;
    logic [PW-1:0] w_skid_pl;
    logic [PW-1:0] w_in_pl;
    logic [PW-1:0] w_main_d;
    logic          w_main_load;
    logic          w_main_clear;
    logic          w_skid_load;
    logic          w_skid_clear;
    logic          w_main_free;
    logic          w_in_xfer;

    logic [EXC_W-1:0] w_exc;
    logic             w_pred;
    logic [XLEN-1:0]  w_addr;
    logic [ILEN-1:0]  w_inst;

    assign w_in_pl     = {exc_i, pred_taken_i, inst_addr_i, inst_i};
    assign w_main_free = !w_main_v || out_ready_i;

    // With the skid, ready depends only on a flop, breaking the decode->fetch path
    assign in_ready_o = SKID_EN ? !w_skid_v : w_main_free;
    assign w_in_xfer  = in_valid_i && in_ready_o;

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_main_d     = w_in_pl;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (flush_i) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_main_free) begin
            if (w_skid_v) begin
                w_main_load = 1'b1;
                w_main_d    = w_skid_pl;
                if (w_in_xfer) w_skid_load  = 1'b1;
                else           w_skid_clear = 1'b1;
            end else if (w_in_xfer) begin
                w_main_load = 1'b1;
            end else begin
                w_main_clear = 1'b1;
            end
        end else if (w_in_xfer) begin
            w_skid_load = 1'b1;
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_v),
        .o_data  (w_main_pl)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_pl),
        .o_valid (w_skid_v),
        .o_data  (w_skid_pl)
    );

    assign {w_exc, w_pred, w_addr, w_inst} = w_main_pl;

    // Bubble values come from the valid bit, so stale payload never leaks
    assign out_valid_o  = w_main_v;
    assign inst_o       = w_main_v ? w_inst : NOP_INST;
    assign inst_addr_o  = w_main_v ? w_addr : '0;
    assign pred_taken_o = w_main_v && w_pred;
    assign exc_o        = w_main_v ? w_exc : '0;

endmodule
